// File: rtl/run_detect_pkg.sv
// Shared types and defaults for the run detector controller.
// State encodings are visible on state_out, so they are fixed here.
package run_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2,
    ST_HIT   = 2'd3
  } state_t;

  localparam int N_W_DEF       = 4;
  localparam int DEFAULT_N_DEF = 3;
  localparam int CNT_W_DEF     = 8;

  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/run_detect_ctrl_sat_counter.sv
// Saturating up-counter with clear and load-one controls (clear has priority).
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Counter register: stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= W'(1);
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/run_detect_ctrl.sv
// Run detector controller: threshold config, run tracking FSM, detect flag.
// Optional detection counter on hit_count when RUN_DETECT_HIT_COUNT_EN is defined.
module run_detect_ctrl
  import run_detect_pkg::*;
#(
  parameter int N_W       = N_W_DEF,
  parameter int DEFAULT_N = DEFAULT_N_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             save,
  input  logic [N_W-1:0]   n_in,
  input  logic             start,
  input  logic             stop,
  input  logic             w,
  input  logic             w_valid,
  output logic             z,
  output logic [N_W-1:0]   run_len,
  output logic             busy,
  output logic             cfg_err,
`ifdef RUN_DETECT_HIT_COUNT_EN
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] hit_count
`else
  output logic [1:0]       state_out
`endif
);

  if (DEFAULT_N <= 0 || DEFAULT_N >= (1 << N_W) || CNT_W < 1) begin : g_param_check
    $error("run_detect_ctrl: DEFAULT_N must be in 1..2^N_W-1 and CNT_W >= 1");
  end

  state_t         state;
  state_t         state_next;
  logic [N_W-1:0] n_reg;
  logic           last_bit;
  logic           z_next;
  logic           busy_next;
  logic           rl_clear;
  logic           rl_load1;
  logic           rl_inc;
  logic           bit_load;
  logic           w_match;
  logic [N_W-1:0] rl_inc_val;
  logic [N_W-1:0] track_len;
  logic           save_ok;

  assign w_match    = (w == last_bit);
  assign rl_inc_val = (run_len == {N_W{1'b1}}) ? run_len : (run_len + N_W'(1));
  assign track_len  = w_match ? rl_inc_val : N_W'(1);
  assign save_ok    = (state == ST_IDLE) || (state == ST_ARMED);
  assign state_out  = state;

  // State register with registered z/busy derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      z     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      z     <= z_next;
      busy  <= busy_next;
    end
  end

  // Next-state logic and run-length counter controls; stop overrides everything.
  always_comb begin
    state_next = state;
    rl_clear   = 1'b0;
    rl_load1   = 1'b0;
    rl_inc     = 1'b0;
    bit_load   = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
      rl_clear   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_ARMED;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (w_valid) begin
            bit_load = 1'b1;
            rl_load1 = 1'b1;
            if (n_reg == N_W'(1)) begin
              state_next = ST_HIT;
            end else begin
              state_next = ST_TRACK;
            end
          end else begin
            state_next = ST_ARMED;
          end
        end
        ST_TRACK: begin
          if (w_valid) begin
            if (w_match) begin
              rl_inc = 1'b1;
            end else begin
              rl_load1 = 1'b1;
              bit_load = 1'b1;
            end
            if (track_len >= n_reg) begin
              state_next = ST_HIT;
            end else begin
              state_next = ST_TRACK;
            end
          end else begin
            state_next = ST_TRACK;
          end
        end
        ST_HIT: begin
          if (w_valid) begin
            if (w_match) begin
              rl_inc     = 1'b1;
              state_next = ST_HIT;
            end else begin
              rl_load1 = 1'b1;
              bit_load = 1'b1;
              if (n_reg == N_W'(1)) begin
                state_next = ST_HIT;
              end else begin
                state_next = ST_TRACK;
              end
            end
          end else begin
            state_next = ST_HIT;
          end
        end
        default: begin
          state_next = ST_IDLE;
          rl_clear   = 1'b1;
        end
      endcase
    end
  end

  // Output decode from the next state so z/busy line up with state_out.
  always_comb begin
    z_next    = (state_next == ST_HIT);
    busy_next = is_busy(state_next);
  end

  // Remembered polarity of the run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_bit <= 1'b0;
    end else if (bit_load) begin
      last_bit <= w;
    end else begin
      last_bit <= last_bit;
    end
  end

  // Threshold and sticky config error; only a valid save in IDLE/ARMED clears the error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg   <= N_W'(DEFAULT_N);
      cfg_err <= 1'b0;
    end else if (save) begin
      if (save_ok && (n_in != '0)) begin
        n_reg   <= n_in;
        cfg_err <= 1'b0;
      end else begin
        n_reg   <= n_reg;
        cfg_err <= 1'b1;
      end
    end else begin
      n_reg   <= n_reg;
      cfg_err <= cfg_err;
    end
  end

  sat_counter #(.W(N_W)) u_run_len (
    .clk   (clk),
    .rst   (rst),
    .clear (rl_clear),
    .load1 (rl_load1),
    .inc   (rl_inc),
    .count (run_len)
  );

`ifdef RUN_DETECT_HIT_COUNT_EN
  logic hit_enter;

  // A HIT entry is any sample that lands in HIT except staying on a matching bit.
  assign hit_enter = w_valid && !stop && (state_next == ST_HIT) &&
                     ((state != ST_HIT) || !w_match);

  sat_counter #(.W(CNT_W)) u_hit_count (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .load1 (1'b0),
    .inc   (hit_enter),
    .count (hit_count)
  );
`endif

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Scoreboard bench for run_detect_ctrl: stimulus pushes expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_run_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       save = 1'b0;
  logic [3:0] n_in = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       w = 1'b0;
  logic       w_valid = 1'b0;
  logic       z;
  logic [3:0] run_len;
  logic       busy;
  logic       cfg_err;
  logic [1:0] state_out;
`ifdef RUN_DETECT_HIT_COUNT_EN
  logic [7:0] hit_count;
`endif

  typedef struct {
    string      name;
    logic       z;
    logic [3:0] rl;
    logic [1:0] st;
    logic       cfg;
    logic [7:0] hc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  run_detect_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .save      (save),
    .n_in      (n_in),
    .start     (start),
    .stop      (stop),
    .w         (w),
    .w_valid   (w_valid),
    .z         (z),
    .run_len   (run_len),
    .busy      (busy),
    .cfg_err   (cfg_err),
`ifdef RUN_DETECT_HIT_COUNT_EN
    .state_out (state_out),
    .hit_count (hit_count)
`else
    .state_out (state_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.name, ".state"},   {6'd0, state_out}, {6'd0, e.st});
    chk({e.name, ".z"},       {7'd0, z},         {7'd0, e.z});
    chk({e.name, ".run_len"}, {4'd0, run_len},   {4'd0, e.rl});
    chk({e.name, ".busy"},    {7'd0, busy},      {7'd0, (e.st != 2'd0)});
    chk({e.name, ".cfg_err"}, {7'd0, cfg_err},   {7'd0, e.cfg});
`ifdef RUN_DETECT_HIT_COUNT_EN
    chk({e.name, ".hit_count"}, hit_count, e.hc);
`endif
  endtask

  // One clock of stimulus; expectation describes outputs after this edge.
  task automatic step(input logic sv, input logic [3:0] ni, input logic sa, input logic sp,
                      input logic wb, input logic wv, input string nm, input logic ez,
                      input logic [3:0] erl, input logic [1:0] est, input logic ecfg,
                      input logic [7:0] ehc);
    exp_t e;
    save = sv; n_in = ni; start = sa; stop = sp; w = wb; w_valid = wv;
    @(posedge clk);
    #1;
    e.name = nm; e.z = ez; e.rl = erl; e.st = est; e.cfg = ecfg; e.hc = ehc;
    q.push_back(e);
    save = 1'b0; start = 1'b0; stop = 1'b0; w_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic sample(input logic wb, input string nm, input logic ez, input logic [3:0] erl,
                        input logic [1:0] est, input logic ecfg, input logic [7:0] ehc);
    step(1'b0, 4'd0, 1'b0, 1'b0, wb, 1'b1, nm, ez, erl, est, ecfg, ehc);
  endtask

  // Monitor: compare the oldest expectation against the settled outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) chk_all(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, "reset_idle", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, "idle_ignores_w", 0, 0, 0, 0, 0);

    // reset mid-TRACK with run_len=2
    step(0, 0, 1, 0, 0, 0, "a_start", 0, 0, 1, 0, 0);
    sample(1, "a_s1", 0, 1, 2, 0, 0);
    sample(1, "a_s2", 0, 2, 2, 0, 0);
    #2 rst = 1'b0;
    #1;
    e.name = "async_reset"; e.z = 0; e.rl = 0; e.st = 0; e.cfg = 0; e.hc = 0;
    chk_all(e);
    @(negedge clk);
    rst = 1'b1;

    // n=4, run of four ones then a break
    step(1, 4, 0, 0, 0, 0, "b_save4", 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, "b_start", 0, 0, 1, 0, 0);
    sample(1, "b_s1", 0, 1, 2, 0, 0);
    sample(1, "b_s2", 0, 2, 2, 0, 0);
    step(0, 0, 1, 0, 0, 0, "b_start_ignored", 0, 2, 2, 0, 0);
    sample(1, "b_s3", 0, 3, 2, 0, 0);
    sample(1, "b_s4", 1, 4, 3, 0, 1);
    sample(0, "b_s5", 0, 1, 2, 0, 1);
    step(0, 0, 0, 1, 0, 0, "b_stop", 0, 0, 0, 0, 1);

    // invalid saves: n=0 in IDLE, any save in HIT
    step(1, 3, 0, 0, 0, 0, "c_save3", 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, "c_save0", 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0, "c_start", 0, 0, 1, 1, 1);
    sample(0, "c_s1", 0, 1, 2, 1, 1);
    sample(0, "c_s2", 0, 2, 2, 1, 1);
    sample(0, "c_s3", 1, 3, 3, 1, 2);
    step(1, 5, 0, 0, 0, 0, "c_save_in_hit", 1, 3, 3, 1, 2);
    sample(1, "c_t1", 0, 1, 2, 1, 2);
    sample(1, "c_t2", 0, 2, 2, 1, 2);
    sample(1, "c_t3_n_still3", 1, 3, 3, 1, 3);
    step(0, 0, 0, 1, 0, 0, "c_stop", 0, 0, 0, 1, 3);
    step(1, 2, 0, 0, 0, 0, "c_save2_clears", 0, 0, 0, 0, 3);

    // n=2, alternating samples with idle gaps
    step(0, 0, 1, 0, 0, 0, "d_start", 0, 0, 1, 0, 3);
    for (int i = 0; i < 4; i++) begin
      sample(~i[0], "d_sample", 0, 1, 2, 0, 3);
      for (int j = 0; j < 3; j++) step(0, 0, 0, 0, i[0], 0, "d_gap", 0, 1, 2, 0, 3);
    end
    step(0, 0, 0, 1, 0, 0, "d_stop", 0, 0, 0, 0, 3);

    // n=1: every sample is a HIT entry
    step(1, 1, 0, 0, 0, 0, "e_save1", 0, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 0, "e_start", 0, 0, 1, 0, 3);
    sample(1, "e_s1", 1, 1, 3, 0, 4);
    sample(0, "e_s2", 1, 1, 3, 0, 5);
    sample(1, "e_s3", 1, 1, 3, 0, 6);
    step(0, 0, 0, 1, 0, 0, "e_stop", 0, 0, 0, 0, 6);

    // n=15: saturation of run_len
    step(1, 15, 0, 0, 0, 0, "f_save15", 0, 0, 0, 0, 6);
    step(0, 0, 1, 0, 0, 0, "f_start", 0, 0, 1, 0, 6);
    for (int i = 1; i <= 20; i++) begin
      if (i < 15) sample(1, "f_run", 0, 4'(i), 2, 0, 6);
      else        sample(1, "f_sat", 1, 4'd15, 3, 0, 7);
    end
    step(0, 0, 1, 1, 0, 0, "f_stop_start", 0, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, "f_idle_hold", 0, 0, 0, 0, 7);

    // save+start in IDLE uses new n; stop+save in ARMED both apply
    step(1, 2, 1, 0, 0, 0, "g_save_start", 0, 0, 1, 0, 7);
    sample(0, "g_s1", 0, 1, 2, 0, 7);
    sample(0, "g_s2", 1, 2, 3, 0, 8);
    step(0, 0, 0, 1, 0, 0, "g_stop", 0, 0, 0, 0, 8);
    step(0, 0, 1, 0, 0, 0, "g_start", 0, 0, 1, 0, 8);
    step(1, 1, 0, 1, 0, 0, "g_stop_save", 0, 0, 0, 0, 8);
    step(0, 0, 1, 0, 0, 0, "g_start2", 0, 0, 1, 0, 8);
    sample(1, "g_n1_hit", 1, 1, 3, 0, 9);
    step(0, 0, 0, 1, 0, 0, "g_stop2", 0, 0, 0, 0, 9);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_detect_ctrl.md
Name: run_detect_ctrl

Overview:
Controller that configures and sequences the n-consecutive-ones/zeros run detector used in the lab datapath.
- Latches threshold n through a save strobe.
- Arms on start, samples serial bit w on each w_valid, and tracks the current run length.
- Raises z while a run of length >= n is in progress.
- Keeps a saturating count of detections for the LED/HEX display layer.

Parameters:
N_W, 4, width of threshold n and of the run-length counter
DEFAULT_N, 3, threshold loaded at reset (must be non-zero, < 2^N_W)
CNT_W, 8, width of hit counter (present only with HIT_COUNT_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
save  input  1  single-cycle strobe: load n_in as threshold
n_in  input  N_W  threshold value presented with save
start  input  1  single-cycle strobe: arm detector from IDLE
stop  input  1  single-cycle strobe: abort to IDLE from any state
w  input  1  serial data bit
w_valid  input  1  w is sampled only in cycles where w_valid=1
z  output  1  registered detect flag
run_len  output  N_W  current run length, saturating
busy  output  1  high in ARMED, TRACK, HIT
cfg_err  output  1  sticky configuration error flag
state_out  output  2  encoded state: IDLE=0, ARMED=1, TRACK=2, HIT=3
hit_count  output  CNT_W  number of HIT entries (HIT_COUNT_EN only)

Behaviour:
- Reset (rst=0, async) forces: state IDLE, n_reg=DEFAULT_N, run_len=0, last_bit=0, z=0, cfg_err=0, hit_count=0.
- All outputs are registered; z, run_len and state_out reflect a sample one cycle after the w_valid edge.
- save in IDLE/ARMED:
  - n_in != 0: n_reg <= n_in, cfg_err <= 0.
  - n_in == 0: n_reg unchanged, cfg_err <= 1.
- save in TRACK/HIT: ignored, cfg_err <= 1. cfg_err clears only on a valid save.
- IDLE: start -> ARMED. w_valid ignored. run_len=0, z=0.
- ARMED: first w_valid sets last_bit <= w, run_len <= 1, then:
  - n_reg == 1 -> HIT.
  - otherwise -> TRACK.
- TRACK, on w_valid:
  - w == last_bit: run_len <= sat(run_len+1).
  - otherwise: run_len <= 1, last_bit <= w.
  - If the new run_len >= n_reg -> HIT.
  - No w_valid: hold all state.
- HIT: z=1.
  - w_valid with w == last_bit: stay in HIT, run_len saturating increment.
  - w_valid with w != last_bit: run_len <= 1, last_bit <= w, go to TRACK (or re-enter HIT if n_reg == 1).
- z: 1 exactly while state == HIT, 0 otherwise.
- Saturation: run_len stops at 2^N_W-1 and never wraps.
- start in ARMED/TRACK/HIT: ignored.
- stop in any state: -> IDLE, run_len <= 0, z <= 0. n_reg and hit_count are retained.
- Simultaneous events:
  - stop+start: stop wins.
  - save+start in IDLE: both take effect; the new n is used.
  - stop+save in ARMED: both take effect.

Optional Feature:
Macro RUN_DETECT_HIT_COUNT_EN.
- Defined: hit_count port exists. It increments by 1 on every transition into HIT from ARMED or TRACK, including HIT -> HIT re-entry when n_reg == 1. It saturates at 2^CNT_W-1, is cleared only by reset, and is unaffected by stop.
- Undefined: hit_count port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package run_detect_pkg: state enum (IDLE, ARMED, TRACK, HIT with the encodings above), DEFAULT_N, N_W/CNT_W defaults.
- One natural sub-module: sat_counter (parameterised width, inc/clear/load-1 controls, saturating). Instantiated for run_len and for hit_count.

Test Plan:
- Reset mid-TRACK with run_len=2: assert rst=0 -> immediately state_out=0, z=0, run_len=0, n_reg=3.
- save with n_in=4, start, then w=1,1,1,1 on w_valid -> z=1 one cycle after the 4th sample, run_len=4, state_out=3. Next sample w=0 -> z=0, run_len=1, state_out=2.
- save with n_in=0 -> cfg_err=1 and n stays 3. Then w=0,0,0 -> z=1 after the 3rd. A save during HIT -> cfg_err remains 1 and n is unchanged.
- n=2, samples 1,0,1,0 with w_valid gaps of 3 idle cycles -> run_len toggles 1,1,1,1, z never asserts, state held between samples.
- n=1 with RUN_DETECT_HIT_COUNT_EN: samples 1,0,1 -> z=1 throughout, hit_count=3. Then stop -> IDLE, z=0, hit_count stays 3.
- N_W=4, n=15: 20 identical samples -> run_len saturates at 15 with no wrap, z=1 from the 15th sample. stop and start in the same cycle -> IDLE.
